mem_port_arbiter: RTL

- Shares the single-ported unified instruction/data RAM between two requesters:
  - the fetch stage (I-port, 80-bit instruction reads);
  - the memory stage (D-port, 64-bit reads and writes).
- Sits between the CPU sequencer/stages and the RAM.
- Owns all RAM strobes, address and write data.
- Returns per-port responses with a one-cycle ack pulse.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D RAM port arbiter: FSM state
// encoding, owner codes and per-port access sizes used for bounds checks.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned INSTR_BYTES = 10;
    localparam int unsigned DATA_BYTES  = 8;

    // Highest legal start address for an access of access_bytes bytes.
    function automatic logic [63:0] last_legal_addr(input logic [63:0] mem_bytes,
                                                    input logic [63:0] access_bytes);
        return mem_bytes - access_bytes;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the I/D RAM arbiter.
// Build option MEM_ARB_RR_EN: when defined, simultaneous requests are
// resolved round-robin using i_prefer_i; otherwise D always beats I and
// the preference input is ignored.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_prefer_i,
    output logic o_grant,
    output logic o_owner_d
);

    assign o_grant = i_if_req | i_d_req;

`ifdef MEM_ARB_RR_EN
    // On a tie, hand the RAM to the port that was not granted last.
    always_comb begin
        o_owner_d = 1'b0;
        if (i_if_req && i_d_req) begin
            o_owner_d = ~i_prefer_i;
        end else begin
            o_owner_d = i_d_req;
        end
    end
`else
    logic w_unused_prefer_i;
    assign w_unused_prefer_i = i_prefer_i;

    // Fixed priority: the memory stage wins any tie.
    always_comb begin
        o_owner_d = i_d_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified RAM between the fetch stage
// (80-bit instruction reads) and the memory stage (64-bit reads/writes).
// One transaction at a time: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking (default:
// fixed D-over-I priority, no pointer state).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RAM_LAT   = 1,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [79:0] if_instr,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        ram_read_en,
    output logic        ram_read_instruction,
    output logic        ram_write_en,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    input  logic [63:0] ram_rdata,
    input  logic [79:0] ram_rinstr,
    input  logic        ram_err,
    output logic        busy
);

    localparam logic [63:0] LIM_I    = last_legal_addr(64'(MEM_BYTES), 64'(INSTR_BYTES));
    localparam logic [63:0] LIM_D    = last_legal_addr(64'(MEM_BYTES), 64'(DATA_BYTES));
    localparam logic [2:0]  CNT_LOAD = 3'(RAM_LAT - 1);

    state_t      r_state;
    owner_t      r_owner;
    logic        r_we;
    logic        r_bounds_err;
    logic [2:0]  r_cnt;
    logic        r_if_ack;
    logic [79:0] r_if_instr;
    logic        r_if_err;
    logic        r_d_ack;
    logic [63:0] r_d_rdata;
    logic        r_d_err;
    logic        r_ram_read_en;
    logic        r_ram_read_instr;
    logic        r_ram_write_en;
    logic [63:0] r_ram_addr;
    logic [63:0] r_ram_wdata;
    logic        r_prefer_i;

    logic        w_grant;
    logic        w_pick_d;
    logic        w_is_wr;
    logic        w_oob;
    logic [63:0] w_req_addr;
    logic        w_enter_resp;

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer_i <= 1'b0;
        end else if (r_state == ST_IDLE && w_grant) begin
            r_prefer_i <= w_pick_d;
        end
    end
`else
    // No pointer in fixed-priority builds.
    assign r_prefer_i = 1'b0;
`endif

    mem_arb_pick u_pick (
        .i_if_req   (if_req),
        .i_d_req    (d_req),
        .i_prefer_i (r_prefer_i),
        .o_grant    (w_grant),
        .o_owner_d  (w_pick_d)
    );

    // Request decode: address, direction and bounds check for the winner.
    // Comparisons are full 64-bit so huge addresses cannot wrap into range.
    assign w_req_addr = w_pick_d ? d_addr : if_addr;
    assign w_is_wr    = w_pick_d & d_we;
    assign w_oob      = w_pick_d ? (d_addr > LIM_D) : (if_addr > LIM_I);

    // RAM data is sampled on the edge that enters RESP.
    assign w_enter_resp = ((r_state == ST_ISSUE) && (RAM_LAT == 1)) ||
                          ((r_state == ST_WAIT)  && (r_cnt == 3'd1));

    // Main FSM with registered strobes and per-port responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_owner          <= OWN_D;
            r_we             <= 1'b0;
            r_bounds_err     <= 1'b0;
            r_cnt            <= 3'd0;
            r_if_ack         <= 1'b0;
            r_if_instr       <= '0;
            r_if_err         <= 1'b0;
            r_d_ack          <= 1'b0;
            r_d_rdata        <= '0;
            r_d_err          <= 1'b0;
            r_ram_read_en    <= 1'b0;
            r_ram_read_instr <= 1'b0;
            r_ram_write_en   <= 1'b0;
            r_ram_addr       <= '0;
            r_ram_wdata      <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_pick_d ? OWN_D : OWN_I;
                        r_we         <= w_is_wr;
                        r_bounds_err <= w_oob;
                        r_state      <= ST_ISSUE;
                        // Out-of-range accesses never touch the RAM.
                        if (!w_oob) begin
                            r_ram_read_en    <= ~w_is_wr;
                            r_ram_read_instr <= ~w_pick_d;
                            r_ram_write_en   <= w_is_wr;
                            r_ram_addr       <= w_req_addr;
                            r_ram_wdata      <= w_is_wr ? d_wdata : 64'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_ram_read_en    <= 1'b0;
                    r_ram_read_instr <= 1'b0;
                    r_ram_write_en   <= 1'b0;
                    r_ram_addr       <= '0;
                    r_ram_wdata      <= '0;
                    r_cnt            <= CNT_LOAD;
                    r_state          <= (RAM_LAT == 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_resp) begin
                if (r_owner == OWN_I) begin
                    r_if_ack   <= 1'b1;
                    r_if_instr <= r_bounds_err ? 80'd0 : ram_rinstr;
                    r_if_err   <= r_bounds_err | ram_err;
                end else begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= (r_bounds_err || r_we) ? 64'd0 : ram_rdata;
                    r_d_err   <= r_bounds_err | ram_err;
                end
            end
        end
    end

    assign if_ack               = r_if_ack;
    assign if_instr             = r_if_instr;
    assign if_err               = r_if_err;
    assign d_ack                = r_d_ack;
    assign d_rdata              = r_d_rdata;
    assign d_err                = r_d_err;
    assign ram_read_en          = r_ram_read_en;
    assign ram_read_instruction = r_ram_read_instr;
    assign ram_write_en         = r_ram_write_en;
    assign ram_addr             = r_ram_addr;
    assign ram_wdata            = r_ram_wdata;
    assign busy                 = (r_state != ST_IDLE);

endmodule
